rl_fifo_1r1w_ctrl: RTL and testbench
====================================

Name: rl_fifo_1r1w_ctrl

Overview:
- Synchronous FWFT FIFO controller that sequences one rl_ram_1r1w instance as backing storage.
- Valid/ready stream on both sides. RAM read latency is 1 cycle, so a 2-entry output buffer with read prefetch hides it and sustains 1 word/cycle.
- Used as the standard buffering element wherever a 1R1W RAM backs a queue.

Parameters:
ABITS, 4, RAM address width; RAM depth 2**ABITS
DBITS, 32, data width
AFULL_LVL, 2**ABITS, almost_full asserted when count >= AFULL_LVL
AEMPTY_LVL, 1, almost_empty asserted when count <= AEMPTY_LVL
TECHNOLOGY, "GENERIC", passed unchanged to rl_ram_1r1w

Ports:
clk  in  1  clock
rstn  in  1  reset: one clock; reset is synchronous and active-low
clr  in  1  synchronous flush, active high
s_data  in  DBITS  write data
s_valid  in  1  write request
s_ready  out  1  FIFO can accept; push = s_valid & s_ready
m_data  out  DBITS  head-of-queue data
m_valid  out  1  m_data valid
m_ready  in  1  consumer accept; pop = m_valid & m_ready
count  out  ABITS+2  total words held
empty  out  1  count==0
full  out  1  equals !s_ready
almost_full  out  1  count >= AFULL_LVL
almost_empty  out  1  count <= AEMPTY_LVL

Behaviour:
- Capacity is 2**ABITS+2: RAM plus 2-entry output buffer (ob).
- State:
  - wptr, rptr: ABITS+1 bits, MSB is the wrap bit.
  - ram_cnt = wptr - rptr.
  - rd_pend: 1 bit, RAM read issued last cycle.
  - ob: 2 entries, ob_cnt 0..2.
- Push:
  - RAM we=1 at waddr=wptr[ABITS-1:0]; wptr increments.
  - s_ready = (ram_cnt < 2**ABITS), registered.
  - Push while full is ignored, with no state change.
- Prefetch:
  - Issue RAM re at raddr=rptr[ABITS-1:0] when ram_cnt>0 and (ob_cnt + rd_pend - pop) < 2; rptr increments.
  - ram_cnt uses registered wptr, so a word is never read in its write cycle. No read-during-write hazard.
- Capture: in the cycle after re (rd_pend=1), RAM dout is written into the ob tail.
- Pop: m_data/m_valid come from the ob head; head advances on pop.
  - Pop and capture in the same cycle are both honoured; ob_cnt is unchanged.
- count = ram_cnt + rd_pend + ob_cnt.
  - count, empty, full, almost_full, almost_empty are registered, computed from next-state values.
- Latency, empty FIFO: push in cycle t → count=1 at t+1, re at t+1, m_valid=1 with data at t+2.
- Throughput: continuous push and pop give 1 word/cycle after start-up, with no bubbles.
- Simultaneous push and pop when full: pop frees ob space, a prefetch follows, and s_ready re-asserts the next cycle. No word is lost or duplicated.
- Pointer wrap is natural modulo 2**(ABITS+1). Order is preserved across wraps.
- rstn=0 at a clk edge:
  - wptr=rptr=0, rd_pend=0, ob_cnt=0.
  - m_valid=0, m_data=0, s_ready=1, count=0.
  - empty=1, full=0, almost_full=(AFULL_LVL==0), almost_empty=1.
- clr=1 has the same effect as reset on control state. A push or pop in the clr cycle is discarded, and an in-flight read is dropped. RAM contents are not cleared.
- rstn has priority over clr.
- RAM connections: be all ones, re/we as above, rstn/clk shared.

Decomposition:
- Shared package rl_fifo_pkg:
  - function fifo_capacity(abits) = 2**abits+2;
  - localparam OB_DEPTH=2.
- Sub-module rl_fifo_ob: 2-entry output buffer with capture/pop/count and m_data/m_valid.
- Top holds pointers, prefetch logic and flags, and instantiates rl_ram_1r1w and rl_fifo_ob.

Test Plan (ABITS=2, DBITS=8, AFULL_LVL=5, AEMPTY_LVL=1; capacity 6):
1. Reset: hold rstn=0 for 2 edges, s_valid=1 → s_ready=1, m_valid=0, count=0, empty=1; no words stored after release.
2. Single word: push 0xA5 at t with m_ready=0 → count=1 at t+1, m_valid=1 and m_data=0xA5 at t+2. Pop at t+3 → empty=1 at t+4.
3. Fill/drain: push 0x00..0x09 back-to-back with m_ready=0 → exactly 0x00..0x05 accepted, full=1, count=6, almost_full from count=5. Then m_ready=1 → 0x00..0x05 out on 6 consecutive cycles, then m_valid=0, empty=1.
4. Streaming: s_valid=1 and m_ready=1 continuously, incrementing data → first output at t+2, then one word per cycle with no gaps; count constant at 2.
5. Wrap/backpressure: 40 words with random s_valid and m_ready → output order exactly matches input across ≥5 pointer wraps; count matches the scoreboard each cycle.
6. Flush: count=3 with a push during clr → next cycle count=0, m_valid=0, empty=1. A following push of 0x11 yields m_data=0x11 two cycles later.

Source files
------------

// File: rtl/rl_fifo_pkg.sv
// rtl/rl_fifo_pkg.sv - shared constants and helpers for the 1R1W FIFO controller
package rl_fifo_pkg;

   localparam int OB_DEPTH = 2;

   // Total words held: RAM depth plus the output buffer that hides RAM read latency.
   function automatic int fifo_capacity(input int abits);
      return (2 ** abits) + OB_DEPTH;
   endfunction

endpackage

// File: rtl/rl_fifo_ob.sv
// rtl/rl_fifo_ob.sv - two-entry output buffer with RAM read-data bypass
module rl_fifo_ob
   import rl_fifo_pkg::*;
#(
   parameter int DBITS = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             cap_valid,
   input  logic [DBITS-1:0] cap_data,
   output logic [DBITS-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [1:0]       ob_cnt
);

   logic [DBITS-1:0] e0, e1;
   logic             pop;

   // With the buffer empty, a word arriving from the RAM is presented directly.
   assign m_valid = (ob_cnt != 2'd0) | cap_valid;
   assign m_data  = (ob_cnt != 2'd0) ? e0 : (cap_valid ? cap_data : '0);
   assign pop     = m_valid & m_ready;

   always_ff @(posedge clk) begin
      if (!rstn || clr) begin
         ob_cnt <= 2'd0;
         e0     <= '0;
         e1     <= '0;
      end else begin
         case (ob_cnt)
            2'd0: begin
               if (cap_valid && !pop) begin
                  e0     <= cap_data;
                  ob_cnt <= 2'd1;
               end
            end
            2'd1: begin
               if (pop && cap_valid) begin
                  e0 <= cap_data;
               end else if (pop) begin
                  ob_cnt <= 2'd0;
               end else if (cap_valid) begin
                  e1     <= cap_data;
                  ob_cnt <= 2'd2;
               end
            end
            default: begin
               if (pop) begin
                  e0 <= e1;
                  if (cap_valid) e1 <= cap_data;
                  else           ob_cnt <= 2'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/rl_ram_1r1w.sv
// rtl/rl_ram_1r1w.sv - one-read one-write RAM with registered read data
module rl_ram_1r1w #(
   parameter int ABITS      = 4,
   parameter int DBITS      = 32,
   parameter     TECHNOLOGY = "GENERIC"
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 we,
   input  logic [ABITS-1:0]     waddr,
   input  logic [DBITS-1:0]     din,
   input  logic [DBITS/8-1:0]   be,
   input  logic                 re,
   input  logic [ABITS-1:0]     raddr,
   output logic [DBITS-1:0]     dout
);

   logic [DBITS-1:0] mem [2**ABITS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < DBITS/8; b++) begin
            if (be[b]) mem[waddr][b*8 +: 8] <= din[b*8 +: 8];
         end
      end
   end

   // Hard macros have no output reset; only the generic model clears dout.
   always_ff @(posedge clk) begin
      if (!rstn && TECHNOLOGY == "GENERIC") dout <= '0;
      else if (re)                          dout <= mem[raddr];
   end

endmodule

// File: rtl/rl_fifo_1r1w_ctrl.sv
// rtl/rl_fifo_1r1w_ctrl.sv - FWFT FIFO controller sequencing a 1R1W RAM with read prefetch
module rl_fifo_1r1w_ctrl
   import rl_fifo_pkg::*;
#(
   parameter int ABITS      = 4,
   parameter int DBITS      = 32,
   parameter int AFULL_LVL  = 2**ABITS,
   parameter int AEMPTY_LVL = 1,
   parameter     TECHNOLOGY = "GENERIC"
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic [DBITS-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [DBITS-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [ABITS+1:0] count,
   output logic             empty,
   output logic             full,
   output logic             almost_full,
   output logic             almost_empty
);

   localparam int CW = ABITS + 2;
   localparam logic [CW-1:0] AF_L = CW'(AFULL_LVL);
   localparam logic [CW-1:0] AE_L = CW'(AEMPTY_LVL);

   logic [ABITS:0]   wptr, rptr, wptr_n, rptr_n, ram_cnt, ram_cnt_n;
   logic             rd_pend, re, we, push, pop;
   logic [1:0]       ob_cnt;
   logic [2:0]       ob_need;
   logic [CW-1:0]    count_n;
   logic [DBITS-1:0] ram_dout;

   assign push    = s_valid & s_ready;
   assign pop     = m_valid & m_ready;
   assign we      = push & rstn & ~clr;
   assign ram_cnt = wptr - rptr;

   // Buffer slots still claimed after this cycle; prefetch only while one is free.
   // ram_cnt uses the registered wptr, so a word is never read in its write cycle.
   assign ob_need = {1'b0, ob_cnt} + {2'b00, rd_pend} - {2'b00, pop};
   assign re      = !clr && (ram_cnt != '0) && (ob_need < 3'(OB_DEPTH));

   assign wptr_n    = wptr + {{ABITS{1'b0}}, push};
   assign rptr_n    = rptr + {{ABITS{1'b0}}, re};
   assign ram_cnt_n = wptr_n - rptr_n;
   assign count_n   = {1'b0, ram_cnt_n} + CW'(re) + CW'(ob_need);

   always_ff @(posedge clk) begin
      if (!rstn || clr) begin
         wptr         <= '0;
         rptr         <= '0;
         rd_pend      <= 1'b0;
         s_ready      <= 1'b1;
         count        <= '0;
         empty        <= 1'b1;
         full         <= 1'b0;
         almost_full  <= (AF_L == '0);
         almost_empty <= 1'b1;
      end else begin
         wptr         <= wptr_n;
         rptr         <= rptr_n;
         rd_pend      <= re;
         s_ready      <= !ram_cnt_n[ABITS];
         count        <= count_n;
         empty        <= (count_n == '0);
         full         <= ram_cnt_n[ABITS];
         almost_full  <= (count_n >= AF_L);
         almost_empty <= (count_n <= AE_L);
      end
   end

   rl_ram_1r1w #(
      .ABITS      (ABITS),
      .DBITS      (DBITS),
      .TECHNOLOGY (TECHNOLOGY)
   ) u_ram (
      .clk   (clk),
      .rstn  (rstn),
      .we    (we),
      .waddr (wptr[ABITS-1:0]),
      .din   (s_data),
      .be    ({(DBITS/8){1'b1}}),
      .re    (re),
      .raddr (rptr[ABITS-1:0]),
      .dout  (ram_dout)
   );

   rl_fifo_ob #(
      .DBITS (DBITS)
   ) u_ob (
      .clk       (clk),
      .rstn      (rstn),
      .clr       (clr),
      .cap_valid (rd_pend),
      .cap_data  (ram_dout),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .ob_cnt    (ob_cnt)
   );

endmodule

// File: tb/tb_rl_fifo_1r1w_ctrl.sv
// tb/tb_rl_fifo_1r1w_ctrl.sv - directed self-checking bench for rl_fifo_1r1w_ctrl
module tb_rl_fifo_1r1w_ctrl;
   import rl_fifo_pkg::*;

   localparam int ABITS = 2;
   localparam int DBITS = 8;
   localparam int CAP   = fifo_capacity(ABITS);

   logic             clk = 1'b0;
   logic             rstn, clr, s_valid, s_ready, m_valid, m_ready;
   logic             empty, full, almost_full, almost_empty;
   logic [DBITS-1:0] s_data, m_data;
   logic [ABITS+1:0] count;

   int checks   = 0;
   int failures = 0;

   rl_fifo_1r1w_ctrl #(
      .ABITS      (ABITS),
      .DBITS      (DBITS),
      .AFULL_LVL  (5),
      .AEMPTY_LVL (1),
      .TECHNOLOGY ("GENERIC")
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .clr          (clr),
      .s_data       (s_data),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .m_data       (m_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .count        (count),
      .empty        (empty),
      .full         (full),
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] q[$];
      logic [7:0] exp_d;
      int         sent, got, held, cyc, cexp;
      logic       do_push, do_pop;

      // 1. reset with a push attempt held during it
      rstn = 1'b0; clr = 1'b0; s_valid = 1'b1; s_data = 8'h77; m_ready = 1'b0;
      tick(); tick();
      chk("rst_s_ready", s_ready, 1);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_afull", almost_full, 0);
      chk("rst_aempty", almost_empty, 1);
      rstn = 1'b1; s_valid = 1'b0;
      tick();
      chk("rel_count", count, 0);
      chk("rel_m_valid", m_valid, 0);

      // 2. single word latency
      s_data = 8'hA5; s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      chk("one_count_t1", count, 1);
      chk("one_m_valid_t1", m_valid, 0);
      tick();
      chk("one_m_valid_t2", m_valid, 1);
      chk("one_m_data_t2", m_data, 8'hA5);
      tick();
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      chk("one_empty_t4", empty, 1);
      chk("one_count_t4", count, 0);
      chk("one_m_valid_t4", m_valid, 0);

      // 3. fill beyond capacity, then drain
      for (int i = 0; i < 10; i++) begin
         s_data = 8'(i); s_valid = 1'b1;
         tick();
         cexp = (i + 1 < CAP) ? i + 1 : CAP;
         chk($sformatf("fill_count_%0d", i), count, cexp);
         chk($sformatf("fill_afull_%0d", i), almost_full, (cexp >= 5) ? 1 : 0);
         chk($sformatf("fill_full_%0d", i), full, (i >= 5) ? 1 : 0);
      end
      s_valid = 1'b0; m_ready = 1'b1;
      for (int j = 0; j < 6; j++) begin
         chk($sformatf("drain_valid_%0d", j), m_valid, 1);
         chk($sformatf("drain_data_%0d", j), m_data, j);
         tick();
      end
      chk("drain_m_valid_end", m_valid, 0);
      chk("drain_empty_end", empty, 1);
      m_ready = 1'b0;

      // 4. streaming push and pop every cycle
      s_valid = 1'b1; m_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         s_data = 8'(8'h40 + c);
         if (c < 2) begin
            chk($sformatf("strm_valid_%0d", c), m_valid, 0);
         end else begin
            chk($sformatf("strm_valid_%0d", c), m_valid, 1);
            chk($sformatf("strm_data_%0d", c), m_data, 8'h40 + c - 2);
         end
         chk($sformatf("strm_count_%0d", c), count, (c < 2) ? c : 2);
         tick();
      end
      s_valid = 1'b0;
      tick(); tick(); tick(); tick();
      chk("strm_empty_end", empty, 1);
      m_ready = 1'b0;

      // 5. random backpressure across many pointer wraps
      sent = 0; got = 0; cyc = 0;
      while ((got < 40) && (cyc < 2000)) begin
         s_valid = (sent < 40) && ($urandom_range(0, 3) != 0);
         s_data  = 8'(8'h80 + sent);
         m_ready = ($urandom_range(0, 1) == 1);
         #4;
         do_push = s_valid & s_ready;
         do_pop  = m_valid & m_ready;
         if (do_push) begin
            q.push_back(s_data);
            sent++;
         end
         if (do_pop) begin
            if (q.size() == 0) begin
               chk("rnd_pop_unexpected", 1, 0);
            end else begin
               exp_d = q.pop_front();
               chk($sformatf("rnd_data_%0d", got), m_data, exp_d);
            end
            got++;
         end
         tick();
         held = q.size();
         chk($sformatf("rnd_count_c%0d", cyc), count, held);
         cyc++;
      end
      chk("rnd_all_received", got, 40);
      s_valid = 1'b0; m_ready = 1'b0;

      // 6. flush with a push in the clr cycle
      for (int k = 0; k < 3; k++) begin
         s_data = 8'(8'h30 + k); s_valid = 1'b1;
         tick();
      end
      chk("flush_pre_count", count, 3);
      clr = 1'b1; s_data = 8'hEE;
      tick();
      clr = 1'b0; s_valid = 1'b0;
      chk("flush_count", count, 0);
      chk("flush_m_valid", m_valid, 0);
      chk("flush_empty", empty, 1);
      chk("flush_s_ready", s_ready, 1);
      s_data = 8'h11; s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      tick();
      chk("flush_post_valid", m_valid, 1);
      chk("flush_post_data", m_data, 8'h11);
      chk("flush_post_count", count, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
